// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanout path.
// Holds the reference 640x480@60 timing constants, frame-buffer and colour
// widths, and the helpers for frame-buffer addressing and 3-bit to 24-bit
// colour expansion.
package vga_pkg;

  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 751;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 491;

  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned COLOUR_W  = 3;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned DAC_W     = 8;

  typedef logic [COLOUR_W-1:0] colour_t;

  typedef struct packed {
    logic [DAC_W-1:0] r;
    logic [DAC_W-1:0] g;
    logic [DAC_W-1:0] b;
  } rgb_t;

  // y*160 + x as shift-add; result wraps to the address width.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] fy,
                                                   input logic [CNT_W-1:0] fx);
    logic [FB_ADDR_W-1:0] y;
    y = FB_ADDR_W'(fy);
    return (y << 7) + (y << 5) + FB_ADDR_W'(fx);
  endfunction

  // Each colour bit drives a full DAC channel; en=0 forces black.
  function automatic rgb_t expand_colour(input colour_t c, input logic en);
    rgb_t px;
    px.r = {DAC_W{c[2] & en}};
    px.g = {DAC_W{c[1] & en}};
    px.b = {DAC_W{c[0] & en}};
    return px;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port plus VGA DAC pins of the scanout block.
//   master : scanout side (drives address, sync, blank, RGB, frame start)
//   slave  : memory / board side (returns read data, observes pins)
interface vga_scanout_if;
  import vga_pkg::*;

  logic [FB_ADDR_W-1:0] oRdAddr;
  logic [COLOUR_W-1:0]  iRdData;
  logic                 oHS;
  logic                 oVS;
  logic                 oBlank_n;
  logic [DAC_W-1:0]     oR;
  logic [DAC_W-1:0]     oG;
  logic [DAC_W-1:0]     oB;
  logic                 oFrameStart;

  modport master (
    output oRdAddr, oHS, oVS, oBlank_n, oR, oG, oB, oFrameStart,
    input  iRdData
  );

  modport slave (
    input  oRdAddr, oHS, oVS, oBlank_n, oR, oG, oB, oFrameStart,
    output iRdData
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical).
//   iClock/iReset : clock, synchronous active-high reset
//   iEn           : advance strobe
//   count         : position 0..TOTAL-1
//   wrap          : count is at TOTAL-1 (next advance returns to 0)
//   sync_n        : low while count is in [SYNC_START, SYNC_END]
//   active        : count < VISIBLE
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL,
  parameter int unsigned SYNC_START = H_SYNC_START,
  parameter int unsigned SYNC_END   = H_SYNC_END,
  parameter int unsigned VISIBLE    = 640
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iEn,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_n,
  output logic             active
);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      count <= '0;
    end else if (iEn) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

  always_comb begin
    wrap   = (count == CNT_W'(TOTAL - 1));
    sync_n = !((count >= CNT_W'(SYNC_START)) && (count <= CNT_W'(SYNC_END)));
    active = (count < CNT_W'(VISIBLE));
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: reads a 160x120 3-bit frame buffer and drives the DAC at
// 640x480@60 with 4x4 pixel replication.
//   iClock  : system clock
//   iReset  : synchronous active-high reset
//   iPixEn  : pixel tick; all state advances only when high
//   bus     : master side of vga_scanout_if (read address/data, HS, VS,
//             blank, RGB, frame-start pulse)
// Counter value to pin latency is two pixel ticks: the first tick registers
// the decode and read address, the second registers the returned data.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned FB_WIDTH    = 160
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic          iPixEn,
  vga_scanout_if.master bus
);

  localparam int unsigned H_PERIOD     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_PERIOD     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_FIRST = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_LAST  = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int unsigned V_SYNC_FIRST = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_LAST  = V_VISIBLE + V_FRONT + V_SYNC - 1;

  logic [CNT_W-1:0]     hcount, vcount;
  logic                 h_wrap, v_wrap;
  logic                 h_sync_n, v_sync_n;
  logic                 h_active, v_active;
  logic                 visible;
  logic [CNT_W-1:0]     fx, fy;
  logic [FB_ADDR_W-1:0] rd_addr;

  logic                 vis_d1, hs_d1, vs_d1;
  logic                 at_origin;
  rgb_t                 pix_rgb;

  vga_axis_counter #(
    .TOTAL      (H_PERIOD),
    .SYNC_START (H_SYNC_FIRST),
    .SYNC_END   (H_SYNC_LAST),
    .VISIBLE    (H_VISIBLE)
  ) u_hcount (
    .iClock (iClock),
    .iReset (iReset),
    .iEn    (iPixEn),
    .count  (hcount),
    .wrap   (h_wrap),
    .sync_n (h_sync_n),
    .active (h_active)
  );

  vga_axis_counter #(
    .TOTAL      (V_PERIOD),
    .SYNC_START (V_SYNC_FIRST),
    .SYNC_END   (V_SYNC_LAST),
    .VISIBLE    (V_VISIBLE)
  ) u_vcount (
    .iClock (iClock),
    .iReset (iReset),
    .iEn    (iPixEn && h_wrap),
    .count  (vcount),
    .wrap   (v_wrap),
    .sync_n (v_sync_n),
    .active (v_active)
  );

  always_comb begin
    visible = h_active && v_active;
    fx      = hcount >> SCALE_SHIFT;
    fy      = vcount >> SCALE_SHIFT;
  end

  if (FB_WIDTH == 160) begin : g_addr_shift
    always_comb rd_addr = fb_addr(fy, fx);
  end else begin : g_addr_mul
    always_comb rd_addr = FB_ADDR_W'(32'(fy) * FB_WIDTH + 32'(fx));
  end

  always_comb pix_rgb = expand_colour(bus.iRdData, vis_d1);

  // at_origin tracks "stage-0 counters are (0,0)" as a registered flag
  // predicted from the wrap terms, instead of a 20-bit compare.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      vis_d1       <= 1'b0;
      hs_d1        <= 1'b1;
      vs_d1        <= 1'b1;
      at_origin    <= 1'b1;
      bus.oRdAddr  <= '0;
      bus.oHS      <= 1'b1;
      bus.oVS      <= 1'b1;
      bus.oBlank_n <= 1'b0;
      bus.oR       <= '0;
      bus.oG       <= '0;
      bus.oB       <= '0;
    end else if (iPixEn) begin
      vis_d1       <= visible;
      hs_d1        <= h_sync_n;
      vs_d1        <= v_sync_n;
      at_origin    <= h_wrap && v_wrap;
      if (visible) begin
        bus.oRdAddr <= rd_addr;
      end
      bus.oHS      <= hs_d1;
      bus.oVS      <= vs_d1;
      bus.oBlank_n <= vis_d1;
      bus.oR       <= pix_rgb.r;
      bus.oG       <= pix_rgb.g;
      bus.oB       <= pix_rgb.b;
    end
  end

  always_comb bus.oFrameStart = iPixEn && at_origin && !iReset;

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;
  import vga_pkg::*;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pins_t;

  localparam int unsigned FB_WORDS = 19200;
  localparam pins_t RESET_PINS = {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic pixen = 1'b0;
  always #5 clk = ~clk;

  vga_scanout_if bus_f ();
  vga_scanout_if bus_s ();

  // index 0: full 640x480 timing, index 1: reduced timing so whole frames fit
  vga_scanout dut_full (
    .iClock (clk),
    .iReset (rst),
    .iPixEn (pixen),
    .bus    (bus_f)
  );

  vga_scanout #(
    .H_VISIBLE (64),
    .H_FRONT   (4),
    .H_SYNC    (8),
    .H_BACK    (4),
    .V_VISIBLE (32),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (3)
  ) dut_small (
    .iClock (clk),
    .iReset (rst),
    .iPixEn (pixen),
    .bus    (bus_s)
  );

  logic [2:0] mem [FB_WORDS];
  always_comb bus_f.iRdData = (int'(bus_f.oRdAddr) < FB_WORDS) ? mem[bus_f.oRdAddr] : 3'b000;
  always_comb bus_s.iRdData = (int'(bus_s.oRdAddr) < FB_WORDS) ? mem[bus_s.oRdAddr] : 3'b000;

  int unsigned htot  [2] = '{800, 80};
  int unsigned hvis  [2] = '{640, 64};
  int unsigned hs_lo [2] = '{656, 68};
  int unsigned hs_hi [2] = '{751, 75};
  int unsigned vtot  [2] = '{525, 39};
  int unsigned vvis  [2] = '{480, 32};
  int unsigned vs_lo [2] = '{490, 34};
  int unsigned vs_hi [2] = '{491, 35};

  // Reference model: enabled ticks since reset and last visible address.
  int unsigned n      [2];
  logic [14:0] addr_m [2];

  int checks   = 0;
  int failures = 0;

  function automatic int unsigned fb_index(int unsigned h, int unsigned v);
    return (v / 4) * 160 + h / 4;
  endfunction

  function automatic pins_t expect_pins(int d, int unsigned ticks);
    pins_t o;
    int unsigned p, h, v;
    logic [2:0] c;
    o = RESET_PINS;
    if (ticks >= 2) begin
      p = (ticks - 2) % (htot[d] * vtot[d]);
      h = p % htot[d];
      v = p / htot[d];
      o.hs      = !(h >= hs_lo[d] && h <= hs_hi[d]);
      o.vs      = !(v >= vs_lo[d] && v <= vs_hi[d]);
      o.blank_n = (h < hvis[d]) && (v < vvis[d]);
      if (o.blank_n) begin
        c   = mem[fb_index(h, v)];
        o.r = c[2] ? 8'hFF : 8'h00;
        o.g = c[1] ? 8'hFF : 8'h00;
        o.b = c[0] ? 8'hFF : 8'h00;
      end
    end
    return o;
  endfunction

  function automatic logic expect_fs(int d);
    return pixen && !rst && ((n[d] % (htot[d] * vtot[d])) == 0);
  endfunction

  function automatic pins_t actual_pins(int d);
    if (d == 0) return {bus_f.oHS, bus_f.oVS, bus_f.oBlank_n, bus_f.oR, bus_f.oG, bus_f.oB};
    return {bus_s.oHS, bus_s.oVS, bus_s.oBlank_n, bus_s.oR, bus_s.oG, bus_s.oB};
  endfunction

  function automatic logic [14:0] actual_addr(int d);
    return (d == 0) ? bus_f.oRdAddr : bus_s.oRdAddr;
  endfunction

  function automatic logic actual_fs(int d);
    return (d == 0) ? bus_f.oFrameStart : bus_s.oFrameStart;
  endfunction

  task automatic drive(input logic r, input logic e);
    rst   = r;
    pixen = e;
    #1;
  endtask

  task automatic advance();
    int unsigned p, h, v;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        n[d]      = 0;
        addr_m[d] = '0;
      end else if (pixen) begin
        p = n[d] % (htot[d] * vtot[d]);
        h = p % htot[d];
        v = p / htot[d];
        if (h < hvis[d] && v < vvis[d]) addr_m[d] = 15'(fb_index(h, v));
        n[d]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1);
    advance();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (actual_fs(d) !== 1'b0) begin
          failures++;
          $display("FAIL reset_fs d%0d got=%b exp=0", d, actual_fs(d));
        end
      end
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (actual_pins(d) !== RESET_PINS) begin
          failures++;
          $display("FAIL reset_pins d%0d got=%h exp=%h", d, actual_pins(d), RESET_PINS);
        end
        checks++;
        if (actual_addr(d) !== 15'd0) begin
          failures++;
          $display("FAIL reset_addr d%0d got=%0d exp=0", d, actual_addr(d));
        end
      end
    end
    drive(1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (actual_fs(d) !== 1'b1) begin
        failures++;
        $display("FAIL release_fs d%0d got=%b exp=1", d, actual_fs(d));
      end
    end
  endtask

  task automatic test_line_timing();
    pins_t act;
    int first_blank = -1, second_blank = -1, first_hs = -1;
    int blank_cnt = 0, hs_cnt = 0;
    logic prev_blank = 1'b0;
    for (int i = 0; i < FB_WORDS; i++) mem[i] = 3'b111;
    do_reset();
    for (int i = 0; i < 1700; i++) begin
      drive(1'b0, 1'b1);
      checks++;
      if (actual_fs(0) !== expect_fs(0)) begin
        failures++;
        $display("FAIL line_fs n=%0d got=%b exp=%b", n[0], actual_fs(0), expect_fs(0));
      end
      advance();
      act = actual_pins(0);
      checks++;
      if (act !== expect_pins(0, n[0])) begin
        failures++;
        $display("FAIL line_pins n=%0d got=%h exp=%h", n[0], act, expect_pins(0, n[0]));
      end
      if (act.blank_n && !prev_blank) begin
        if (first_blank < 0) first_blank = int'(n[0]);
        else if (second_blank < 0) second_blank = int'(n[0]);
      end
      prev_blank = act.blank_n;
      if (n[0] <= 800) begin
        if (act.blank_n) blank_cnt++;
        if (!act.hs) begin
          hs_cnt++;
          if (first_hs < 0) first_hs = int'(n[0]);
        end
      end
    end
    checks++;
    if (first_blank != 2) begin
      failures++;
      $display("FAIL blank_start got=%0d exp=2", first_blank);
    end
    checks++;
    if (blank_cnt != 640) begin
      failures++;
      $display("FAIL blank_len got=%0d exp=640", blank_cnt);
    end
    checks++;
    if (second_blank != 802) begin
      failures++;
      $display("FAIL line_period got=%0d exp=802", second_blank);
    end
    checks++;
    if (first_hs != 658) begin
      failures++;
      $display("FAIL hs_start got=%0d exp=658", first_hs);
    end
    checks++;
    if (hs_cnt != 96) begin
      failures++;
      $display("FAIL hs_len got=%0d exp=96", hs_cnt);
    end
  endtask

  task automatic test_frame_timing();
    pins_t act;
    int unsigned fs_at [$];
    int vs_cnt = 0, first_vs = -1, leak = 0;
    for (int i = 0; i < FB_WORDS; i++) mem[i] = 3'($urandom);
    do_reset();
    for (int i = 0; i < 6440; i++) begin
      drive(1'b0, 1'b1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (actual_fs(d) !== expect_fs(d)) begin
          failures++;
          $display("FAIL frame_fs d%0d n=%0d got=%b exp=%b", d, n[d], actual_fs(d), expect_fs(d));
        end
      end
      if (actual_fs(1) === 1'b1) fs_at.push_back(n[1]);
      advance();
      act = actual_pins(1);
      checks++;
      if (act !== expect_pins(1, n[1])) begin
        failures++;
        $display("FAIL frame_pins n=%0d got=%h exp=%h", n[1], act, expect_pins(1, n[1]));
      end
      checks++;
      if (actual_addr(1) !== addr_m[1]) begin
        failures++;
        $display("FAIL frame_addr n=%0d got=%0d exp=%0d", n[1], actual_addr(1), addr_m[1]);
      end
      if (!act.blank_n && {act.r, act.g, act.b} != 24'h0) leak++;
      if (n[1] >= 1 && n[1] <= 3120 && !act.vs) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = int'(n[1]);
      end
    end
    checks++;
    if (fs_at.size() != 3 || fs_at[1] - fs_at[0] != 3120 || fs_at[2] - fs_at[1] != 3120) begin
      failures++;
      $display("FAIL fs_period pulses=%0d exp=3 spaced 3120", fs_at.size());
    end
    checks++;
    if (vs_cnt != 160) begin
      failures++;
      $display("FAIL vs_len got=%0d exp=160", vs_cnt);
    end
    checks++;
    if (first_vs != 2722) begin
      failures++;
      $display("FAIL vs_start got=%0d exp=2722", first_vs);
    end
    checks++;
    if (leak != 0) begin
      failures++;
      $display("FAIL rgb_outside_visible got=%0d exp=0", leak);
    end
  endtask

  task automatic test_addressing();
    pins_t act;
    int unsigned p, h, v;
    for (int i = 0; i < FB_WORDS; i++) mem[i] = 3'(i);
    do_reset();
    for (int i = 0; i < 5614; i++) begin
      drive(1'b0, 1'b1);
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (actual_addr(d) !== addr_m[d]) begin
          failures++;
          $display("FAIL addr d%0d n=%0d got=%0d exp=%0d", d, n[d], actual_addr(d), addr_m[d]);
        end
      end
      if (n[0] == 3205) begin
        checks++;
        if (bus_f.oRdAddr !== 15'd161) begin
          failures++;
          $display("FAIL addr_4_4 got=%0d exp=161", bus_f.oRdAddr);
        end
      end
      if (n[1] == 2544 || n[1] == 3120) begin
        checks++;
        if (bus_s.oRdAddr !== 15'd1135) begin
          failures++;
          $display("FAIL addr_last n=%0d got=%0d exp=1135", n[1], bus_s.oRdAddr);
        end
      end
      p = n[0] - 2;
      h = p % 800;
      v = p / 800;
      if (n[0] >= 2 && h >= 4 && h <= 7 && v >= 4 && v <= 7) begin
        act = actual_pins(0);
        checks++;
        if ({act.r, act.g, act.b} !== 24'h0000FF) begin
          failures++;
          $display("FAIL block_colour h=%0d v=%0d got=%h exp=0000ff", h, v, {act.r, act.g, act.b});
        end
      end
    end
  endtask

  task automatic test_colour();
    for (int i = 0; i < FB_WORDS; i++) mem[i] = 3'($urandom);
    mem[0]   = 3'b010;
    mem[161] = 3'b101;
    do_reset();
    for (int i = 0; i < 3206; i++) begin
      drive(1'b0, 1'b1);
      advance();
      if (n[0] == 2) begin
        checks++;
        if ({bus_f.oR, bus_f.oG, bus_f.oB} !== 24'h00FF00) begin
          failures++;
          $display("FAIL colour_010 got=%h exp=00ff00", {bus_f.oR, bus_f.oG, bus_f.oB});
        end
      end
    end
    checks++;
    if ({bus_f.oBlank_n, bus_f.oR, bus_f.oG, bus_f.oB} !== {1'b1, 24'hFF00FF}) begin
      failures++;
      $display("FAIL colour_101 got=%b/%h exp=1/ff00ff", bus_f.oBlank_n, {bus_f.oR, bus_f.oG, bus_f.oB});
    end
  endtask

  task automatic test_pixen_toggle();
    pins_t prev [2];
    logic e;
    for (int i = 0; i < FB_WORDS; i++) mem[i] = 3'($urandom);
    do_reset();
    for (int i = 0; i < 3400; i++) begin
      e = (i < 1700) ? ((i % 2) == 0) : 1'($urandom);
      drive(1'b0, e);
      for (int d = 0; d < 2; d++) begin
        prev[d] = actual_pins(d);
        checks++;
        if (actual_fs(d) !== expect_fs(d)) begin
          failures++;
          $display("FAIL tog_fs d%0d n=%0d got=%b exp=%b", d, n[d], actual_fs(d), expect_fs(d));
        end
      end
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (actual_pins(d) !== expect_pins(d, n[d])) begin
          failures++;
          $display("FAIL tog_pins d%0d n=%0d got=%h exp=%h", d, n[d], actual_pins(d), expect_pins(d, n[d]));
        end
        checks++;
        if (actual_addr(d) !== addr_m[d]) begin
          failures++;
          $display("FAIL tog_addr d%0d n=%0d got=%0d exp=%0d", d, n[d], actual_addr(d), addr_m[d]);
        end
        if (!e) begin
          checks++;
          if (actual_pins(d) !== prev[d]) begin
            failures++;
            $display("FAIL tog_hold d%0d got=%h exp=%h", d, actual_pins(d), prev[d]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_disabled();
    drive(1'b1, 1'b0);
    advance();
    drive(1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (actual_pins(d) !== RESET_PINS || actual_addr(d) !== 15'd0) begin
        failures++;
        $display("FAIL rst_dis d%0d got=%h/%0d exp=%h/0", d, actual_pins(d), actual_addr(d), RESET_PINS);
      end
      checks++;
      if (actual_fs(d) !== 1'b0) begin
        failures++;
        $display("FAIL rst_dis_fs_idle d%0d got=%b exp=0", d, actual_fs(d));
      end
    end
    advance();
    drive(1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (actual_fs(d) !== 1'b1) begin
        failures++;
        $display("FAIL rst_dis_fs d%0d got=%b exp=1", d, actual_fs(d));
      end
    end
    advance();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (actual_pins(d) !== RESET_PINS || actual_addr(d) !== 15'd0) begin
        failures++;
        $display("FAIL rst_dis_first d%0d got=%h/%0d exp=%h/0", d, actual_pins(d), actual_addr(d), RESET_PINS);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < FB_WORDS; i++) mem[i] = 3'b000;
    @(negedge clk);
    do_reset();
    do_reset();
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_addressing();
    test_colour();
    test_pixen_toggle();
    test_reset_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
